// File: rtl/eq_pkg.sv
// Shared constants and helpers for the equalizer complex-multiply combine stage.
package eq_pkg;

    // Default datapath geometry.
    localparam int EQ_PROD_W = 28;  // signed multiplier product width
    localparam int EQ_LAT    = 4;   // multiplier latency in ce-enabled cycles
    localparam int EQ_SHIFT  = 12;  // right shift applied after combine
    localparam int EQ_OUT_W  = 16;  // signed output width per component
    localparam int EQ_TAG_W  = 6;   // subcarrier index width
    localparam int SAT_CNT_W = 16;  // saturation event counter width

    // Rounding constant for a given shift: half an output LSB.
    function automatic longint f_rnd(input int shift);
        return 64'sd1 <<< (shift - 1);
    endfunction

    // Largest value representable in a signed word of the given width.
    function automatic longint f_out_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed word of the given width.
    function automatic longint f_out_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Values for the default geometry.
    localparam longint RND     = f_rnd(EQ_SHIFT);
    localparam longint OUT_MAX = f_out_max(EQ_OUT_W);
    localparam longint OUT_MIN = f_out_min(EQ_OUT_W);

endpackage

// File: rtl/eq_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation of one
// signed component, with a flag raised whenever the value had to be clipped.
module eq_round_sat
    import eq_pkg::*;
#(
    parameter int IN_W  = EQ_PROD_W + 1,
    parameter int SHIFT = EQ_SHIFT,
    parameter int OUT_W = EQ_OUT_W
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_clip
);

    // One guard bit so adding the rounding constant to the most positive
    // input cannot wrap.
    localparam int EXT_W = IN_W + 1;

    localparam logic signed [EXT_W-1:0] L_RND = EXT_W'(f_rnd(SHIFT));
    localparam logic signed [EXT_W-1:0] L_MAX = EXT_W'(f_out_max(OUT_W));
    localparam logic signed [EXT_W-1:0] L_MIN = EXT_W'(f_out_min(OUT_W));

    logic signed [EXT_W-1:0] w_sum;
    logic signed [EXT_W-1:0] w_shr;

    assign w_sum = {i_val[IN_W-1], i_val} + L_RND;
    assign w_shr = w_sum >>> SHIFT;

    // Clamp the shifted value into the output range and flag any clipping.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_val  = w_shr[OUT_W-1:0];
        o_clip = 1'b0;
        if (w_shr > L_MAX) begin
            o_val  = L_MAX[OUT_W-1:0];
            o_clip = 1'b1;
        end else if (w_shr < L_MIN) begin
            o_val  = L_MIN[OUT_W-1:0];
            o_clip = 1'b1;
        end
    end

endmodule

// File: rtl/equalizer_cmul_combine.sv
// Combines the four partial products of the equalizer multipliers into one
// complex sample, rounds/saturates it, and streams it to the demapper. The
// block owns the multipliers' ce so the whole pipe stalls as one unit.
module equalizer_cmul_combine
    import eq_pkg::*;
#(
    parameter int PROD_W = EQ_PROD_W,
    parameter int LAT    = EQ_LAT,
    parameter int SHIFT  = EQ_SHIFT,
    parameter int OUT_W  = EQ_OUT_W,
    parameter int TAG_W  = EQ_TAG_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     in_last,
    output logic                     mul_ce,
    input  logic signed [PROD_W-1:0] mul_rr,
    input  logic signed [PROD_W-1:0] mul_ii,
    input  logic signed [PROD_W-1:0] mul_ri,
    input  logic signed [PROD_W-1:0] mul_ir,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_re,
    output logic signed [OUT_W-1:0]  out_im,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_last,
    input  logic                     sat_clr,
    output logic [SAT_CNT_W-1:0]     sat_cnt
);

    localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = '1;

    logic                     w_adv;
    logic                     w_load;
    logic signed [PROD_W:0]   w_re_full;
    logic signed [PROD_W:0]   w_im_full;
    logic signed [OUT_W-1:0]  w_re_sat;
    logic signed [OUT_W-1:0]  w_im_sat;
    logic                     w_re_clip;
    logic                     w_im_clip;

    logic [LAT-1:0]           r_vld_sr;
    logic [TAG_W-1:0]         r_tag_sr [LAT];
    logic [LAT-1:0]           r_last_sr;
    logic                     r_out_valid;
    logic signed [OUT_W-1:0]  r_out_re;
    logic signed [OUT_W-1:0]  r_out_im;
    logic [TAG_W-1:0]         r_out_tag;
    logic                     r_out_last;
    logic [SAT_CNT_W-1:0]     r_sat_cnt;

    // The pipe advances whenever the output slot is empty or being drained;
    // the same enable freezes the multipliers so products stay aligned with
    // the valid/tag pipe during a stall.
    assign w_adv    = !r_out_valid || out_ready;
    assign mul_ce   = w_adv;
    assign in_ready = w_adv;
    assign w_load   = w_adv && r_vld_sr[LAT-1];

    // Full-width complex combine; one extra bit absorbs the sum/difference growth.
    assign w_re_full = (PROD_W+1)'(mul_rr) - (PROD_W+1)'(mul_ii);
    assign w_im_full = (PROD_W+1)'(mul_ri) + (PROD_W+1)'(mul_ir);

    eq_round_sat #(
        .IN_W  (PROD_W + 1),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat_re (
        .i_val  (w_re_full),
        .o_val  (w_re_sat),
        .o_clip (w_re_clip)
    );

    eq_round_sat #(
        .IN_W  (PROD_W + 1),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat_im (
        .i_val  (w_im_full),
        .o_val  (w_im_sat),
        .o_clip (w_im_clip)
    );

    // Valid pipe mirroring the multiplier latency; bubbles shift in as zeros.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_sr <= '0;
        end else if (w_adv) begin
            // NOTE: state registers use non-blocking assignment so every stage
            // samples the value from before the edge.
            r_vld_sr <= {r_vld_sr[LAT-2:0], in_valid};
        end
    end

    // Tag/last sideband travelling alongside the valid pipe.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; stale contents are harmless because the valid
        // pipe, which is reset, decides whether they are ever used.
        if (w_adv) begin
            r_tag_sr[0] <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                r_tag_sr[i] <= r_tag_sr[i-1];
            end
            r_last_sr <= {r_last_sr[LAT-2:0], in_last};
        end
    end

    // Output register: loads on advance, holds every field while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_tag   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_vld_sr[LAT-1];
            if (r_vld_sr[LAT-1]) begin
                r_out_re   <= w_re_sat;
                r_out_im   <= w_im_sat;
                r_out_tag  <= r_tag_sr[LAT-1];
                r_out_last <= r_last_sr[LAT-1];
            end
        end
    end

    // Saturating count of loaded samples that clipped in either component;
    // a clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (w_load && (w_re_clip || w_im_clip) && (r_sat_cnt != SAT_CNT_MAX)) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_tag   = r_out_tag;
    assign out_last  = r_out_last;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_equalizer_cmul_combine.sv
// Directed bench for equalizer_cmul_combine with four behavioural 13s x 16s
// multipliers (LAT=4, ce-gated) feeding the product ports.
module tb_equalizer_cmul_combine;

    localparam int PROD_W = 28;
    localparam int LAT    = 4;
    localparam int SHIFT  = 12;
    localparam int OUT_W  = 16;
    localparam int TAG_W  = 6;

    logic                     clk;
    logic                     reset_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [TAG_W-1:0]         in_tag;
    logic                     in_last;
    logic                     mul_ce;
    logic signed [PROD_W-1:0] mul_rr, mul_ii, mul_ri, mul_ir;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_re, out_im;
    logic [TAG_W-1:0]         out_tag;
    logic                     out_last;
    logic                     sat_clr;
    logic [15:0]              sat_cnt;

    logic signed [12:0]       a_re, a_im;
    logic signed [15:0]       b_re, b_im;
    logic signed [PROD_W-1:0] p_rr [LAT], p_ii [LAT], p_ri [LAT], p_ir [LAT];

    int checks   = 0;
    int failures = 0;

    equalizer_cmul_combine #(
        .PROD_W (PROD_W), .LAT (LAT), .SHIFT (SHIFT), .OUT_W (OUT_W), .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tag    (in_tag),
        .in_last   (in_last),
        .mul_ce    (mul_ce),
        .mul_rr    (mul_rr),
        .mul_ii    (mul_ii),
        .mul_ri    (mul_ri),
        .mul_ir    (mul_ir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_tag   (out_tag),
        .out_last  (out_last),
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multipliers: LAT-deep, advancing only on ce.
    always @(posedge clk) begin
        if (mul_ce) begin
            p_rr[0] <= PROD_W'(a_re) * PROD_W'(b_re);
            p_ii[0] <= PROD_W'(a_im) * PROD_W'(b_im);
            p_ri[0] <= PROD_W'(a_re) * PROD_W'(b_im);
            p_ir[0] <= PROD_W'(a_im) * PROD_W'(b_re);
            for (int s = 1; s < LAT; s++) begin
                p_rr[s] <= p_rr[s-1];
                p_ii[s] <= p_ii[s-1];
                p_ri[s] <= p_ri[s-1];
                p_ir[s] <= p_ir[s-1];
            end
        end
    end

    assign mul_rr = p_rr[LAT-1];
    assign mul_ii = p_ii[LAT-1];
    assign mul_ri = p_ri[LAT-1];
    assign mul_ir = p_ir[LAT-1];

    task automatic check(input string name, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic set_ops(input int are, input int aim, input int bre, input int bim,
                           input int tag, input bit last, input bit vld);
        a_re     = 13'(are);
        a_im     = 13'(aim);
        b_re     = 16'(bre);
        b_im     = 16'(bim);
        in_tag   = TAG_W'(tag);
        in_last  = last;
        in_valid = vld;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // One isolated sample with out_ready=1: checks latency, values and tag.
    task automatic run_one(input string name, input int are, input int aim, input int bre,
                           input int bim, input int tag, input int exp_re, input int exp_im);
        int  n;
        bit  seen;
        @(negedge clk);
        set_ops(are, aim, bre, bim, tag, 1'b0, 1'b1);
        check({name, "_in_ready"}, int'(in_ready), 1);
        seen = 1'b0;
        n    = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                seen = 1'b1;
                n    = i;
                break;
            end
        end
        if (seen) begin
            check({name, "_latency"}, n, LAT + 1);
            check({name, "_re"}, int'(out_re), exp_re);
            check({name, "_im"}, int'(out_im), exp_im);
            check({name, "_tag"}, int'(out_tag), tag);
        end else begin
            check({name, "_timeout"}, 0, 1);
        end
    endtask

    bit         pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] lfsr   = 16'hACE1;

    initial begin
        int sent, rcvd, cyc, quiet_hits;
        bit hold;
        int h_re, h_im, h_tag, h_last;
        bit ev;

        reset_n   = 1'b0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;
        set_ops(0, 0, 0, 0, 0, 1'b0, 1'b0);

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_re", int'(out_re), 0);
        check("rst_out_im", int'(out_im), 0);
        check("rst_out_tag", int'(out_tag), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_sat_cnt", int'(sat_cnt), 0);
        check("rst_in_ready", int'(in_ready), 1);
        reset_n = 1'b1;
        idle(2);

        // Basic complex product: (3000-1000j)(8192+4096j)/4096 = 7000+1000j.
        run_one("basic", 3000, -1000, 8192, 4096, 5, 7000, 1000);
        check("basic_sat_cnt", int'(sat_cnt), 0);

        // Round half up at the exact half-LSB boundaries.
        run_one("rnd_pos_half", 1, 0, 2048, 0, 1, 1, 0);
        run_one("rnd_neg_half", -1, 0, 2048, 0, 2, 0, 0);
        run_one("rnd_neg_over", -1, 0, 2049, 0, 3, -1, 0);

        // Saturation of the real part; imaginary part rounds to -8.
        run_one("sat", 4095, -4096, 32767, 32767, 4, 32767, -8);
        check("sat_cnt_one", int'(sat_cnt), 1);
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        check("sat_cnt_clr", int'(sat_cnt), 0);

        // Bubbles: valid pattern 1,0,0,1,1; outputs reproduce the gaps.
        idle(3);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            ev = (k >= 5 && k <= 9) ? pat[k-5] : 1'b0;
            if (k >= 1) check($sformatf("bub_vld_%0d", k), int'(out_valid), int'(ev));
            if (ev) begin
                check($sformatf("bub_re_%0d", k), int'(out_re), (k - 5) * 100 + 7);
                check($sformatf("bub_im_%0d", k), int'(out_im), -(k - 4));
                check($sformatf("bub_tag_%0d", k), int'(out_tag), 40 + k - 5);
            end
            if (k < 5) set_ops(k * 100 + 7, -(k + 1), 4096, 0, 40 + k, 1'b0, pat[k]);
            else       in_valid = 1'b0;
        end

        // Back-pressure: 64 tags with pseudo-random out_ready.
        // Operands a=(10t,-t), b=(8192,4096) give re=21t, im=8t exactly.
        idle(2);
        sent = 0; rcvd = 0; cyc = 0; hold = 1'b0;
        h_re = 0; h_im = 0; h_tag = 0; h_last = 0;
        while (rcvd < 64 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                check("bp_hold_vld", int'(out_valid), 1);
                check("bp_hold_re", int'(out_re), h_re);
                check("bp_hold_im", int'(out_im), h_im);
                check("bp_hold_tag", int'(out_tag), h_tag);
                check("bp_hold_last", int'(out_last), h_last);
            end
            lfsr      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            out_ready = lfsr[0];
            hold      = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    check("bp_tag", int'(out_tag), rcvd);
                    check("bp_re", int'(out_re), 21 * rcvd);
                    check("bp_im", int'(out_im), 8 * rcvd);
                    check("bp_last", int'(out_last), int'(rcvd == 63));
                    rcvd++;
                end else begin
                    hold   = 1'b1;
                    h_re   = int'(out_re);
                    h_im   = int'(out_im);
                    h_tag  = int'(out_tag);
                    h_last = int'(out_last);
                end
            end
            if (sent < 64) set_ops(10 * sent, -sent, 8192, 4096, sent, sent == 63, 1'b1);
            else           in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) sent++;
        end
        check("bp_count", rcvd, 64);
        out_ready = 1'b1;
        idle(8);

        // Reset with three samples in flight.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            set_ops(200 + j, 0, 4096, 0, 50 + j, 1'b0, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_pre_vld", int'(out_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_vld", int'(out_valid), 0);
        check("rst_mid_re", int'(out_re), 0);
        check("rst_mid_tag", int'(out_tag), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        quiet_hits = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) quiet_hits++;
        end
        check("rst_mid_quiet", quiet_hits, 0);
        run_one("post_rst", 123, 0, 4096, 0, 9, 123, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
